operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand fetch unit: decodes the addressing mode, reads the register file
// and/or RAM, and returns the operand with a one-cycle data_valid pulse.
module operand_fetch #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MODE_WIDTH     = 3,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [MODE_WIDTH-1:0]     mode,
  input  logic [ADDR_WIDTH-1:0]     operand_in,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0]     reg_data,
  output logic                      reg_wr_en,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic                      ram_rd_en,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  input  logic [DATA_WIDTH-1:0]     ram_data,
  input  logic                      ram_rd_valid,
  output logic                      data_valid,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      err
);

  localparam int IDX_WIDTH = ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  localparam logic [MODE_WIDTH-1:0] M_IMM   = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] M_DIR   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] M_INDIR = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] M_REG   = MODE_WIDTH'(3);
  localparam logic [MODE_WIDTH-1:0] M_IDX   = MODE_WIDTH'(4);
  localparam logic [MODE_WIDTH-1:0] M_INDPI = MODE_WIDTH'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG_RD,
    S_RAM_RD,
    S_RAM_WAIT,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [MODE_WIDTH-1:0]     r_mode;
  logic [IDX_WIDTH-1:0]      r_idx;
  logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
  logic [ADDR_WIDTH-1:0]     r_ram_addr;
  logic [DATA_WIDTH-1:0]     r_data_out;
  logic                      r_err;
  logic [CNT_WIDTH-1:0]      r_wait_cnt;

  logic                      w_accept;
  logic                      w_timeout;
  logic                      w_indpi_wr;
  logic [ADDR_WIDTH-1:0]     w_idx_addr;

  assign w_accept   = req_valid && req_ready;
  assign w_timeout  = (r_wait_cnt == CNT_LAST);
  assign w_indpi_wr = rst_n && (r_state == S_REG_RD) && (r_mode == M_INDPI);
  assign w_idx_addr = reg_data[ADDR_WIDTH-1:0] + ADDR_WIDTH'(r_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (mode)
            M_DIR:                         w_next = S_RAM_RD;
            M_INDIR, M_REG, M_IDX, M_INDPI: w_next = S_REG_RD;
            default:                       w_next = S_DONE;
          endcase
        end
      end
      S_REG_RD:   w_next = (r_mode == M_REG) ? S_DONE : S_RAM_RD;
      S_RAM_RD:   w_next = S_RAM_WAIT;
      S_RAM_WAIT: if (ram_rd_valid || w_timeout) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Result and address registers are loaded on the edge that enters the
  // state which consumes them, so outputs are stable for that whole state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode     <= '0;
      r_idx      <= '0;
      r_reg_addr <= '0;
      r_ram_addr <= '0;
      r_data_out <= '0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode     <= mode;
            r_idx      <= operand_in[ADDR_WIDTH-1:REG_ADDR_WIDTH];
            r_reg_addr <= operand_in[REG_ADDR_WIDTH-1:0];
            case (mode)
              M_IMM: begin
                r_data_out <= DATA_WIDTH'(operand_in);
                r_err      <= 1'b0;
              end
              M_DIR: r_ram_addr <= operand_in;
              M_INDIR, M_REG, M_IDX, M_INDPI: ;
              default: begin
                r_data_out <= '0;
                r_err      <= 1'b1;
              end
            endcase
          end
        end
        S_REG_RD: begin
          if (r_mode == M_REG) begin
            r_data_out <= reg_data;
            r_err      <= 1'b0;
          end else if (r_mode == M_IDX) begin
            r_ram_addr <= w_idx_addr;
          end else begin
            r_ram_addr <= reg_data[ADDR_WIDTH-1:0];
          end
        end
        S_RAM_RD: r_wait_cnt <= '0;
        S_RAM_WAIT: begin
          if (ram_rd_valid) begin
            r_data_out <= ram_data;
            r_err      <= 1'b0;
          end else if (w_timeout) begin
            r_data_out <= '0;
            r_err      <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by rst_n so an asserted reset masks them immediately.
  assign req_ready   = rst_n && (r_state == S_IDLE);
  assign data_valid  = rst_n && (r_state == S_DONE);
  assign ram_rd_en   = rst_n && (r_state == S_RAM_RD);
  assign reg_wr_en   = w_indpi_wr;
  assign reg_wr_data = w_indpi_wr ? (reg_data + DATA_WIDTH'(1)) : '0;
  assign reg_addr    = r_reg_addr;
  assign ram_addr    = r_ram_addr;
  assign data_out    = r_data_out;
  assign err         = r_err;

endmodule
